// File: rtl/uart_word_tx.sv
// UART 8N1 transmitter for 1-4 byte response words, most-significant byte first.
// Back-to-back frames within a word have no idle gap; done pulses after the final stop bit.
module uart_word_tx #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] data,
   input  logic [2:0]  nbytes,
   output logic        busy,
   output logic        done,
   output logic        stx
);

   localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int unsigned CntW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [2:0]      remain_q;
   logic [31:0]     shift_q;
   logic            busy_q;
   logic            done_q;
   logic            stx_q;

   logic [31:0]     word_aligned;
   logic [2:0]      n_eff;
   logic            bit_end;

   // Left-align the low N bytes so the first byte to send sits at [31:24]; 0 and 5-7 mean 4.
   always_comb begin
      word_aligned = data;
      n_eff        = 3'd4;
      case (nbytes)
         3'd1: begin
            word_aligned = {data[7:0], 24'h0};
            n_eff        = 3'd1;
         end
         3'd2: begin
            word_aligned = {data[15:0], 16'h0};
            n_eff        = 3'd2;
         end
         3'd3: begin
            word_aligned = {data[23:0], 8'h0};
            n_eff        = 3'd3;
         end
         default: ;
      endcase
   end

   assign bit_end = (cnt_q == CntMax);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         remain_q  <= '0;
         shift_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         stx_q     <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (state_q != StIdle) begin
            cnt_q <= bit_end ? '0 : cnt_q + CntW'(1);
         end
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StStart;
                  shift_q  <= word_aligned;
                  remain_q <= n_eff;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  stx_q    <= 1'b0;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q   <= StData;
                  bit_idx_q <= '0;
                  stx_q     <= shift_q[24];
               end
            end
            StData: begin
               if (bit_end) begin
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                     stx_q   <= 1'b1;
                  end else begin
                     // Current byte shifts right so the next bit is always at [24].
                     bit_idx_q      <= bit_idx_q + 3'd1;
                     stx_q          <= shift_q[25];
                     shift_q[31:24] <= {1'b0, shift_q[31:25]};
                  end
               end
            end
            StStop: begin
               if (bit_end) begin
                  remain_q <= remain_q - 3'd1;
                  shift_q  <= shift_q << 8;
                  if (remain_q == 3'd1) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     stx_q   <= 1'b1;
                  end else begin
                     state_q <= StStart;
                     stx_q   <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign stx  = stx_q;

endmodule
